banked_register_file: RTL and testbench
=======================================

Name: banked_register_file

Overview:
- Multi-bank general-purpose register file for the SCC core; successor to the two-context (architectural + microcode) register file.
- Generalised in data width, register count and bank count.
- Adds a hard-wired zero register on the read path, optional same-cycle write-to-read bypass, and a background bank-clear engine with busy/done handshake.
- Sits between decode (addresses, bank select) and execute/writeback (read operands, write data).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- NUM_BANKS, 2, number of register contexts (bank 0 = architectural, bank 1 = microcode)
- ZERO_EN, 1, 1 = register ZERO_REG is hard-wired to zero
- ZERO_REG, 14, index of the hard-wired zero register
- BYPASS, 1, 1 = a write in cycle N is visible on read ports in cycle N

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- bank_sel  in  BANK_W  bank for read/write; BANK_W = max(1, clog2(NUM_BANKS))
- rd  in  ADDR_W  write address, also read address for out_rd
- rs1  in  ADDR_W  read address port 1
- rs2  in  ADDR_W  read address port 2
- write  in  1  write enable
- writeData  in  DATA_W  write data
- write_ready  out  1  0 = write to bank_sel currently blocked by clear engine
- out_rd  out  DATA_W  read data at rd
- out_rs1  out  DATA_W  read data at rs1
- out_rs2  out  DATA_W  read data at rs2
- clr_req  in  1  request clear of bank clr_bank (single-cycle pulse or level)
- clr_bank  in  BANK_W  bank to clear, sampled when request accepted
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (async assert, sync-to-clk deassert by system):
  - all NUM_BANKS x NUM_REGS entries = 0
  - FSM = IDLE; clr_busy = 0; clr_done = 0; write_ready = 1
  - rst mid-clear aborts the clear; all state returns to reset values.
- Reads are combinational from (bank_sel, address).
  - Priority: zero rule > bypass > storage.
  - Zero rule: ZERO_EN=1 and address==ZERO_REG → 0, regardless of storage or bypass.
  - Bypass: BYPASS=1, write=1, write_ready=1, read address==rd → writeData. Applies to out_rs1 and out_rs2; out_rd always shows storage (pre-write value).
  - BYPASS=0: new value visible the cycle after the write edge.
- Write: at posedge, when write=1, write_ready=1 and bank_sel < NUM_BANKS, store[bank_sel][rd] <= writeData.
  - Writes to ZERO_REG (ZERO_EN=1) are discarded; storage stays 0.
- Out-of-range bank_sel (NUM_BANKS not a power of 2): writes ignored, reads return 0.
- write_ready = !(clr_busy && bank_sel == clr_bank_q). Blocked writes are dropped, not queued; the producer must hold them.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 and clr_bank < NUM_BANKS → latch clr_bank_q, idx=0, go to CLEAR. Out-of-range clr_bank is ignored.
  - CLEAR: each cycle store[clr_bank_q][idx] <= 0, idx <= idx+1. After writing idx==NUM_REGS-1, go to DONE. Duration is exactly NUM_REGS cycles with clr_busy=1.
  - DONE: clr_done=1 and clr_busy=0 for one cycle, then IDLE.
  - clr_req is ignored outside IDLE. A request asserted in DONE is not accepted until the next cycle (IDLE).
- Reads of a bank under clear return current storage (partially cleared; entries < idx already 0).
- Writes/reads to other banks proceed unaffected during a clear.
- Clear latency: clr_req accepted at edge E; first zero written at edge E+1; clr_done high in cycle after edge E+NUM_REGS.

Decomposition:
- Shared package scc_rf_pkg:
  - bank index constants BANK_ARCH=0, BANK_UCODE=1
  - clear FSM state enum (IDLE/CLEAR/DONE)
  - default ZERO_REG value
- Sub-module rf_clear_engine: FSM, idx counter, clr_bank_q, clr_busy/clr_done/write_ready generation.
  - Outputs a zero-write strobe, bank and index to the storage array.
- Storage array and read muxing stay in the top module.

Test Plan:
- Reset then write bank0 r3=0xDEADBEEF; next cycle rs1=3 → 0xDEADBEEF; bank1 rs1=3 → 0 (bank isolation).
- Write bank0 r14=0x12345678; read rs2=14 → 0 in the same cycle and the next; also write r5=0xA5A5A5A5 with rs1=5 same cycle → out_rs1=0xA5A5A5A5 (BYPASS=1), out_rd=old value 0.
- Fill bank1 r0..r15 with 0x100+i; clr_req bank1 → clr_busy high exactly 16 cycles; mid-clear (cycle 8) r0..r7 read 0, r8..r15 read 0x108..0x10F; clr_done pulses once; bank0 contents unchanged.
- During clear of bank1: write bank1 r2 → write_ready=0, write dropped, r2 reads 0 afterwards; write bank0 r2=0x55 → accepted.
- Assert rst asynchronously mid-clear (between edges) → outputs zero immediately, FSM IDLE, clr_done never pulses; after release all regs read 0.
- Parameter sweep DATA_W=64, ADDR_W=5, NUM_BANKS=3: write bank2 r31=0xFFFF_FFFF_0000_0001 reads back; bank_sel=3 write ignored and read returns 0; clear of bank2 takes 32 cycles.

Source files
------------

// File: rtl/scc_rf_pkg.sv
// Shared definitions for the SCC banked register file and its clear engine.
package scc_rf_pkg;

    localparam int BANK_ARCH        = 0;
    localparam int BANK_UCODE       = 1;
    localparam int ZERO_REG_DEFAULT = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/rf_clear_engine.sv
// Background bank-clear sequencer: walks one bank writing zeros, one entry per cycle.
// state | meaning
// IDLE  | waiting for an in-range clear request
// CLEAR | zeroing entry r_idx of bank r_bank, busy
// DONE  | one-cycle completion pulse
module rf_clear_engine
    import scc_rf_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_req,
    input  logic [BANK_W-1:0] i_clr_bank,
    input  logic [BANK_W-1:0] i_bank_sel,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_write_ready,
    output logic              o_zero_we,
    output logic [BANK_W-1:0] o_zero_bank,
    output logic [ADDR_W-1:0] o_zero_idx
);

    localparam logic [BANK_W:0]   LP_NUM_BANKS = NUM_BANKS[BANK_W:0];
    localparam logic [ADDR_W-1:0] LP_IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [BANK_W-1:0] r_bank;
    logic              w_accept;

    assign w_accept = i_clr_req && ({1'b0, i_clr_bank} < LP_NUM_BANKS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_bank  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_accept) begin
                r_bank <= i_clr_bank;
                r_idx  <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_idx <= r_idx + LP_IDX_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_clr_busy  = 1'b0;
        o_clr_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                o_clr_busy = 1'b1;
                if (r_idx == '1) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_clr_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Only the bank being swept is locked; other banks keep full write access.
    assign o_write_ready = !(o_clr_busy && (i_bank_sel == r_bank));
    assign o_zero_we     = o_clr_busy;
    assign o_zero_bank   = r_bank;
    assign o_zero_idx    = r_idx;

endmodule

// File: rtl/banked_register_file.sv
// Multi-bank register file with hard-wired zero register, write-to-read bypass
// and a background bank-clear engine.
module banked_register_file
    import scc_rf_pkg::*;
#(
    parameter int   DATA_W    = 32,
    parameter int   ADDR_W    = 4,
    parameter int   NUM_BANKS = 2,
    parameter int   ZERO_EN   = 1,
    parameter int   ZERO_REG  = ZERO_REG_DEFAULT,
    parameter int   BYPASS    = 1,
    localparam int  BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              write,
    input  logic [DATA_W-1:0] writeData,
    output logic              write_ready,
    output logic [DATA_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_rs1,
    output logic [DATA_W-1:0] out_rs2,
    input  logic              clr_req,
    input  logic [BANK_W-1:0] clr_bank,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int                NUM_REGS     = 2 ** ADDR_W;
    localparam logic [BANK_W:0]   LP_NUM_BANKS = NUM_BANKS[BANK_W:0];
    localparam logic [ADDR_W-1:0] LP_ZERO      = ZERO_REG[ADDR_W-1:0];

    logic [DATA_W-1:0] r_mem [NUM_BANKS][NUM_REGS];

    logic              w_zero_we;
    logic [BANK_W-1:0] w_zero_bank;
    logic [ADDR_W-1:0] w_zero_idx;
    logic              w_bank_ok;
    logic              w_wr_fire;
    logic              w_wr_en;
    logic              w_rd_zero;
    logic              w_rs1_zero;
    logic              w_rs2_zero;
    logic              w_rs1_byp;
    logic              w_rs2_byp;

    rf_clear_engine #(
        .ADDR_W    (ADDR_W),
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_clear (
        .clk           (clk),
        .rst           (rst),
        .i_clr_req     (clr_req),
        .i_clr_bank    (clr_bank),
        .i_bank_sel    (bank_sel),
        .o_clr_busy    (clr_busy),
        .o_clr_done    (clr_done),
        .o_write_ready (write_ready),
        .o_zero_we     (w_zero_we),
        .o_zero_bank   (w_zero_bank),
        .o_zero_idx    (w_zero_idx)
    );

    assign w_bank_ok = ({1'b0, bank_sel} < LP_NUM_BANKS);
    assign w_wr_fire = write && write_ready && w_bank_ok;
    assign w_wr_en   = w_wr_fire && !((ZERO_EN != 0) && (rd == LP_ZERO));

    // The clear engine never targets the bank being written (write_ready), so no collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int r = 0; r < NUM_REGS; r++)
                    r_mem[b][r] <= '0;
        end else begin
            if (w_wr_en)
                r_mem[bank_sel][rd] <= writeData;
            if (w_zero_we)
                r_mem[w_zero_bank][w_zero_idx] <= '0;
        end
    end

    assign w_rd_zero  = (ZERO_EN != 0) && (rd  == LP_ZERO);
    assign w_rs1_zero = (ZERO_EN != 0) && (rs1 == LP_ZERO);
    assign w_rs2_zero = (ZERO_EN != 0) && (rs2 == LP_ZERO);
    assign w_rs1_byp  = (BYPASS != 0) && w_wr_fire && (rs1 == rd);
    assign w_rs2_byp  = (BYPASS != 0) && w_wr_fire && (rs2 == rd);

    // Zero rule and bank range dominate bypass; out_rd always shows the pre-write value.
    assign out_rd  = (w_rd_zero  || !w_bank_ok) ? '0 : r_mem[bank_sel][rd];
    assign out_rs1 = (w_rs1_zero || !w_bank_ok) ? '0 :
                     w_rs1_byp ? writeData : r_mem[bank_sel][rs1];
    assign out_rs2 = (w_rs2_zero || !w_bank_ok) ? '0 :
                     w_rs2_byp ? writeData : r_mem[bank_sel][rs2];

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench for banked_register_file: default build plus a 64-bit/32-reg/3-bank build.
`timescale 1ns/1ps
module tb_banked_register_file;
    import scc_rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    // default instance
    logic        b0_sel;
    logic [3:0]  rd0, rs1_0, rs2_0;
    logic        we0;
    logic [31:0] wd0;
    logic        cr0, cb0;
    logic        rdy0, busy0, done0;
    logic [31:0] ord0, ors1_0, ors2_0;

    // wide instance
    logic [1:0]  b1_sel;
    logic [4:0]  rd1, rs1_1, rs2_1;
    logic        we1;
    logic [63:0] wd1;
    logic        cr1;
    logic [1:0]  cb1;
    logic        rdy1, busy1, done1;
    logic [63:0] ord1, ors1_1, ors2_1;

    banked_register_file dut0 (
        .clk(clk), .rst(rst), .bank_sel(b0_sel), .rd(rd0), .rs1(rs1_0), .rs2(rs2_0),
        .write(we0), .writeData(wd0), .write_ready(rdy0), .out_rd(ord0),
        .out_rs1(ors1_0), .out_rs2(ors2_0), .clr_req(cr0), .clr_bank(cb0),
        .clr_busy(busy0), .clr_done(done0)
    );

    banked_register_file #(.DATA_W(64), .ADDR_W(5), .NUM_BANKS(3)) dut1 (
        .clk(clk), .rst(rst), .bank_sel(b1_sel), .rd(rd1), .rs1(rs1_1), .rs2(rs2_1),
        .write(we1), .writeData(wd1), .write_ready(rdy1), .out_rd(ord1),
        .out_rs1(ors1_1), .out_rs2(ors2_1), .clr_req(cr1), .clr_bank(cb1),
        .clr_busy(busy1), .clr_done(done1)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] mem0 [2][16];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [63:0] act);
        if (exp_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else chk(tag_q.pop_front(), act, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model0(input int b, input int a);
        return (a == 14) ? 32'd0 : mem0[b][a];
    endfunction

    task automatic wr0(input logic b, input logic [3:0] a, input logic [31:0] d);
        b0_sel = b; rd0 = a; wd0 = d; we0 = 1'b1;
        tick();
        we0 = 1'b0;
        if (a != 4'd14) mem0[b][a] = d;
    endtask

    task automatic rd0_chk(input string tag, input logic b, input logic [3:0] a);
        b0_sel = b; rs1_0 = a;
        #2;
        sb_push(tag, {32'd0, model0(b, a)});
        sb_pop({32'd0, ors1_0});
    endtask

    int busy_cnt, done_cnt, done_at;

    initial begin
        b0_sel = 0; rd0 = 0; rs1_0 = 0; rs2_0 = 0; we0 = 0; wd0 = 0; cr0 = 0; cb0 = 0;
        b1_sel = 0; rd1 = 0; rs1_1 = 0; rs2_1 = 0; we1 = 0; wd1 = 0; cr1 = 0; cb1 = 0;
        for (int b = 0; b < 2; b++) for (int a = 0; a < 16; a++) mem0[b][a] = 32'd0;

        // reset state
        tick(); tick();
        chk("rst_busy",  {63'd0, busy0}, 64'd0);
        chk("rst_done",  {63'd0, done0}, 64'd0);
        chk("rst_ready", {63'd0, rdy0},  64'd1);
        rst = 1'b0;
        tick();
        rd0_chk("rst_r0", 1'b0, 4'd0);

        // basic write and bank isolation
        wr0(1'b0, 4'd3, 32'hDEADBEEF);
        rd0_chk("b0_r3", 1'b0, 4'd3);
        rd0_chk("b1_r3", 1'b1, 4'd3);

        // zero register and bypass
        b0_sel = 0; rd0 = 4'd14; wd0 = 32'h12345678; we0 = 1; rs2_0 = 4'd14;
        #2;
        sb_push("zero_same", 64'd0); sb_pop({32'd0, ors2_0});
        tick(); we0 = 0; #2;
        sb_push("zero_next", 64'd0); sb_pop({32'd0, ors2_0});
        rd0 = 4'd5; wd0 = 32'hA5A5A5A5; we0 = 1; rs1_0 = 4'd5; #2;
        sb_push("bypass_rs1", 64'hA5A5A5A5); sb_pop({32'd0, ors1_0});
        sb_push("bypass_rd_old", 64'd0);     sb_pop({32'd0, ord0});
        tick(); we0 = 0; mem0[0][5] = 32'hA5A5A5A5; #2;
        sb_push("rd_after", 64'hA5A5A5A5);   sb_pop({32'd0, ord0});

        // fill bank1, then clear it
        for (int i = 0; i < 16; i++) wr0(1'b1, 4'(i), 32'h100 + i);
        rd0_chk("fill_r9", 1'b1, 4'd9);
        cr0 = 1; cb0 = 1;
        tick();
        cr0 = 0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < 22; c++) begin
            if (c > 0) tick();
            if (busy0) busy_cnt++;
            if (done0) begin done_cnt++; done_at = c; end
            if (c == 3) begin
                b0_sel = 1; rd0 = 4'd2; wd0 = 32'hBAD0BAD0; we0 = 1; #1;
                sb_push("blocked_ready", 64'd0); sb_pop({63'd0, rdy0});
            end
            if (c == 4) begin
                b0_sel = 0; rd0 = 4'd2; wd0 = 32'h55; we0 = 1; #1;
                sb_push("other_ready", 64'd1); sb_pop({63'd0, rdy0});
                mem0[0][2] = 32'h55;
            end
            if (c == 5) we0 = 0;
            if (c == 8) begin
                b0_sel = 1;
                for (int i = 0; i < 8; i++) begin
                    rs1_0 = 4'(i); rs2_0 = 4'(i + 8);
                    #2;
                    sb_push($sformatf("mid_lo%0d", i), 64'd0);
                    sb_pop({32'd0, ors1_0});
                    sb_push($sformatf("mid_hi%0d", i + 8), {32'd0, model0(1, i + 8)});
                    sb_pop({32'd0, ors2_0});
                end
                b0_sel = 0;
            end
        end
        for (int a = 0; a < 16; a++) mem0[1][a] = 32'd0;
        chk("clr_busy_cycles", 64'(busy_cnt), 64'd16);
        chk("clr_done_pulses", 64'(done_cnt), 64'd1);
        chk("clr_done_cycle",  64'(done_at),  64'd16);
        rd0_chk("b1_r2_dropped", 1'b1, 4'd2);
        rd0_chk("b1_r15_clear",  1'b1, 4'd15);
        rd0_chk("b0_r3_kept",    1'b0, 4'd3);
        rd0_chk("b0_r5_kept",    1'b0, 4'd5);
        rd0_chk("b0_r2_write",   1'b0, 4'd2);

        // async reset in the middle of a clear
        wr0(1'b1, 4'd7, 32'h77);
        b0_sel = 0; rs1_0 = 4'd3; cr0 = 1; cb0 = 1;
        tick();
        cr0 = 0;
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_busy",  {63'd0, busy0},  64'd0);
        chk("arst_ready", {63'd0, rdy0},   64'd1);
        chk("arst_rs1",   {32'd0, ors1_0}, 64'd0);
        for (int b = 0; b < 2; b++) for (int a = 0; a < 16; a++) mem0[b][a] = 32'd0;
        tick(); tick();
        rst = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done0) done_cnt++;
            if (busy0) busy_cnt++;
        end
        chk("arst_no_done", 64'(done_cnt), 64'd0);
        chk("arst_no_busy", 64'(busy_cnt), 64'd0);
        for (int a = 0; a < 16; a++) begin
            rd0_chk($sformatf("arst_b0_r%0d", a), 1'b0, 4'(a));
            rd0_chk($sformatf("arst_b1_r%0d", a), 1'b1, 4'(a));
        end

        // wide build: 64-bit data, 32 regs, 3 banks
        b1_sel = 2'd2; rd1 = 5'd31; wd1 = 64'hFFFF_FFFF_0000_0001; we1 = 1;
        tick(); we1 = 0;
        rs1_1 = 5'd31; #2;
        sb_push("w_b2_r31", 64'hFFFF_FFFF_0000_0001); sb_pop(ors1_1);
        b1_sel = 2'd3; rd1 = 5'd4; wd1 = 64'hAAAA_5555_AAAA_5555; we1 = 1; rs1_1 = 5'd4; #2;
        sb_push("w_oob_byp", 64'd0); sb_pop(ors1_1);
        tick(); we1 = 0;
        for (int b = 0; b < 4; b++) begin
            b1_sel = 2'(b); rs1_1 = 5'd4; #2;
            sb_push($sformatf("w_oob_b%0d_r4", b), 64'd0); sb_pop(ors1_1);
        end
        cr1 = 1; cb1 = 2'd3;
        tick(); cr1 = 0; #2;
        sb_push("w_oob_clr", 64'd0); sb_pop({63'd0, busy1});
        cr1 = 1; cb1 = 2'd2;
        tick(); cr1 = 0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) tick();
            if (busy1) busy_cnt++;
            if (done1) begin done_cnt++; done_at = c; end
        end
        chk("w_clr_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("w_clr_done_pulses", 64'(done_cnt), 64'd1);
        chk("w_clr_done_cycle",  64'(done_at),  64'd32);
        b1_sel = 2'd2; rs1_1 = 5'd31; #2;
        sb_push("w_b2_r31_clr", 64'd0); sb_pop(ors1_1);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
